// File: rtl/result_display_pkg.sv
// Shared constants for the result display: segment codes, page encoding and scan timing.
// Consumers: result_display (optionally built with LEADING_ZERO_BLANK_EN) and hex_to_7seg.
package result_display_pkg;

  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;

  localparam logic PAGE_HI = 1'b0;
  localparam logic PAGE_LO = 1'b1;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-cold digit enable for digit index d.
  function automatic logic [3:0] an_decode(input logic [1:0] d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Purely combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
  import result_display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/result_display.sv
// Captures the FP adder sum and scans one 16-bit half onto a 4-digit multiplexed display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits of the shown half.
module result_display
  import result_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic        load,
  input  logic        page,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        led_page
);

  localparam logic [15:0] PRE_LAST = 16'(REFRESH_DIV - 1);

  logic [31:0] cap_q, cap_d;
  logic        pg_q, pg_d;
  logic [15:0] pre_q, pre_d;
  logic [1:0]  dig_q, dig_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [15:0] half;
  logic [3:0]  nib;
  logic [6:0]  seg_raw;
  logic        blank;

  hex_to_7seg u_hex_to_7seg (
    .nib_i (nib),
    .seg_o (seg_raw)
  );

  // Load and page may coincide; both update so the new page shows the new capture.
  always_comb begin
    cap_d = load ? result : cap_q;
    pg_d  = page ? ~pg_q : pg_q;
    pre_d = pre_q + 16'd1;
    dig_d = dig_q;
    if (pre_q == PRE_LAST) begin
      pre_d = 16'd0;
      dig_d = dig_q + 2'd1;
    end
  end

  always_comb begin
    half  = (pg_q == PAGE_HI) ? cap_q[31:16] : cap_q[15:0];
    nib   = half[{dig_q, 2'b00} +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (dig_q)
      2'd1:    blank = (half[15:4]  == 12'd0);
      2'd2:    blank = (half[15:8]  == 8'd0);
      2'd3:    blank = (half[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`endif
    an_d  = an_decode(dig_q);
    seg_d = blank ? SEG_BLANK : seg_raw;
    dp_d  = ~((dig_q == 2'd3) && (pg_q == PAGE_HI));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q <= 32'd0;
      pg_q  <= PAGE_HI;
      pre_q <= 16'd0;
      dig_q <= 2'd0;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      cap_q <= cap_d;
      pg_q  <= pg_d;
      pre_q <= pre_d;
      dig_q <= dig_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign led_page = pg_q;

endmodule

// File: tb/tb_result_display.sv
// Table-driven, scoreboarded bench for result_display with a short refresh divider.
module tb_result_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] result;
  logic        load;
  logic        page;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        led_page;

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .result   (result),
    .load     (load),
    .page     (page),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .led_page (led_page)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       led;
  } obs_t;

  typedef struct {
    logic [31:0]      res;
    bit               ld;
    bit               pg;
    logic [3:0][6:0]  seg;   // seg[k] = expected code for digit k
    bit               led;
  } vec_t;

  vec_t vecs[5];
  obs_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the bench on the first negedge where digit 0 is freshly shown.
  task automatic wait_digit0(output bit ok);
    int n = 0;
    while (an == 4'b1110 && n < 64) begin @(negedge clk); n++; end
    while (an != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    ok = (an == 4'b1110);
  endtask

  initial begin
    bit   ok;
    obs_t e;

    reset = 1'b1; load = 1'b0; page = 1'b0; result = 32'd0;
    #12;
    check("reset_state", {an, seg, dp, led_page}, {4'b1111, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{res: 32'h40490FDB, ld: 1, pg: 0, seg: {7'h19, 7'h40, 7'h19, 7'h10}, led: 0};
    vecs[2] = '{res: 32'h3F800000, ld: 1, pg: 1, seg: {7'h30, 7'h0E, 7'h00, 7'h40}, led: 0};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{res: 32'h0, ld: 0, pg: 1, seg: {7'h7F, 7'h0E, 7'h21, 7'h03}, led: 1};
    vecs[3] = '{res: 32'h00000012, ld: 1, pg: 0, seg: {7'h7F, 7'h7F, 7'h7F, 7'h40}, led: 0};
    vecs[4] = '{res: 32'h0, ld: 0, pg: 1, seg: {7'h7F, 7'h7F, 7'h79, 7'h24}, led: 1};
`else
    vecs[1] = '{res: 32'h0, ld: 0, pg: 1, seg: {7'h40, 7'h0E, 7'h21, 7'h03}, led: 1};
    vecs[3] = '{res: 32'h00000012, ld: 1, pg: 0, seg: {7'h40, 7'h40, 7'h40, 7'h40}, led: 0};
    vecs[4] = '{res: 32'h0, ld: 0, pg: 1, seg: {7'h40, 7'h40, 7'h79, 7'h24}, led: 1};
`endif

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      result = vecs[v].res;
      load   = vecs[v].ld;
      page   = vecs[v].pg;
      @(negedge clk);
      load = 1'b0;
      page = 1'b0;
      for (int k = 0; k < 4; k++) begin
        e.an  = ~(4'b0001 << k);
        e.seg = vecs[v].seg[k];
        e.dp  = !(k == 3 && !vecs[v].led);
        e.led = vecs[v].led;
        sbq.push_back(e);
      end
      wait_digit0(ok);
      check($sformatf("v%0d_sync", v), {31'd0, ok}, 32'd1);
      for (int k = 0; k < 4; k++) begin
        e = sbq.pop_front();
        check($sformatf("v%0d_dig%0d", v, k), {19'd0, an, seg, dp, led_page}, {19'd0, e});
        if (k < 3) repeat (4) @(negedge clk);
      end
    end

    // Asynchronous reset mid-digit, with pg=1 so led_page must visibly drop.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset", {an, seg, dp, led_page}, {4'b1111, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_first", {an, seg, dp, led_page}, {4'b1110, 7'h40, 1'b1, 1'b0});
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_dig1", {28'd0, an}, {28'd0, 4'b1101});

    // Three full frames: each enable pattern must persist exactly four cycles.
    @(negedge clk);
    wait_digit0(ok);
    check("timing_sync", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 48; i++) begin
      check($sformatf("timing_%0d", i), {28'd0, an}, {28'd0, ~(4'b0001 << ((i / 4) % 4))});
      @(negedge clk);
    end
    check("timing_wrap", {28'd0, an}, {28'd0, 4'b1110});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
